uart_mmio_buffer: RTL and testbench
===================================

# uart_mmio_buffer

Buffered serial-port controller for GeMIPS. It sits between the memory-address-mapping stage and the `async_receiver`/`async_transmitter` pair. It decouples CPU loads and stores at 0xBFD003F8 (data) and 0xBFD003FC (status) from the 9600-baud link, using a receive FIFO and a transmit FIFO, so bytes are neither lost nor double-sent while the CPU is busy.

## Interface
Parameters:
- `DEPTH`, default 16: entries per FIFO; must be a power of two, 2..256.
- `PTR_W`, default `$clog2(DEPTH)`: FIFO pointer width.

Ports:
- `clk`  in  1  50 MHz system clock
- `rst`  in  1  reset, synchronous, active-high
- `sel_i`  in  1  the bus access targets the serial region
- `reg_i`  in  1  register select: 0 = data (0xBFD003F8), 1 = status (0xBFD003FC)
- `we_i`  in  1  store strobe, valid with `sel_i`
- `re_i`  in  1  load strobe, valid with `sel_i`
- `wdata_i`  in  8  store byte
- `rdata_o`  out  32  load data, combinational
- `rx_ready_i`  in  1  receiver byte-valid flag
- `rx_data_i`  in  8  receiver byte
- `rx_clear_o`  out  1  one-cycle pulse that clears the receiver flag
- `tx_busy_i`  in  1  transmitter busy
- `tx_start_o`  out  1  one-cycle start pulse to the transmitter
- `tx_data_o`  out  8  byte to the transmitter, held stable from the start pulse onward

## Operation
- Reset values: `rx_clear_o=0`, `tx_start_o=0`, `tx_data_o=0`. Both FIFOs are emptied, the overrun flag is cleared, and the TX FSM returns to IDLE.
- RX capture:
  - When `rx_ready_i=1` and `rx_clear_o=0`, push `rx_data_i` and register `rx_clear_o=1` for exactly one cycle.
  - While `rx_clear_o=1`, `rx_ready_i` is ignored.
  - If the RX FIFO is full and no pop happens in the same cycle, the byte is dropped, sticky `overrun` is set, and `rx_clear_o` still pulses.
- Data-register load (`sel_i&re_i&~reg_i`):
  - `rdata_o={24'h0, rx_head}`; the pop occurs at the clock edge.
  - If the RX FIFO is empty, `rdata_o=0` and nothing is popped.
- Status load (`sel_i&re_i&reg_i`):
  - `rdata_o={29'h0, overrun, rx_nonempty, tx_notfull}`.
  - `overrun` clears at the clock edge. If a new overrun occurs in the same cycle, it stays set.
- Data-register store (`sel_i&we_i&~reg_i`): push `wdata_i` into the TX FIFO. If the TX FIFO is full, the store is silently ignored.
- Stores to the status register are ignored. `rdata_o=0` whenever no load is active.
- Simultaneous push and pop on the same FIFO:
  - Both take effect and the count is unchanged.
  - On a full FIFO, the pop frees space, so the push succeeds with no overrun.
  - On an empty FIFO, only the push happens.
- TX FSM:
  - IDLE: if TX FIFO is non-empty and `tx_busy_i=0`, load `tx_data_o` from the head, set `tx_start_o=1`, pop, and go to LAUNCH.
  - LAUNCH: set `tx_start_o=0` and go to HOLD.
  - HOLD: one guard cycle, `busy` ignored (the transmitter raises busy one cycle after start); go to IDLE.
- Occupancy arithmetic: counts are `PTR_W+1` bits, and pointers wrap modulo `DEPTH`.

## Timing
- RX latency: `rx_ready_i` sampled high at edge N makes the byte visible in status bit1 and on the data register from cycle N+1. `rx_clear_o` is high during cycle N+1.
- TX latency:
  - A store at edge N makes the FIFO non-empty in cycle N+1.
  - `tx_start_o` is high during cycle N+2 if the transmitter is idle.
  - The minimum spacing between start pulses is 3 cycles plus the transmitter busy time.
- A load pop and a store push take effect at the same edge as the strobe. The bus never stalls.
- A reset asserted mid-transmission cancels all queued bytes and drives `tx_start_o` low on the next edge. A byte already in the transmitter completes.

## Structure
- Shared package `gemips_uart_pkg`:
  - constants `SERIAL_DATA_ADDR=32'hBFD003F8` and `SERIAL_STAT_ADDR=32'hBFD003FC`
  - status bit indices `STAT_TX_RDY=0`, `STAT_RX_AVAIL=1`, `STAT_OVERRUN=2`
  - TX FSM state typedef `{IDLE, LAUNCH, HOLD}`
- Sub-module `sync_fifo` (parameters `DEPTH` and `W=8`; push, pop, full, empty, head, count), instantiated twice.
- The address-mapping stage decodes the two addresses into `sel_i`/`reg_i`.

## Test plan
- Reset, then a status load: `rdata_o=32'h1`; a data load: `rdata_o=0`; no `tx_start_o` pulse.
- Inject 0x41, 0x42 on `rx_ready_i`: one `rx_clear_o` pulse each; the status reads 0x3; two data loads return 0x41 then 0x42; the status then reads 0x1.
- Inject 17 bytes with `DEPTH=16` and no loads: the status reads 0x7; the first 16 bytes are read back in order; a second status read shows bit2=0.
- Store 0x55, 0xAA with `tx_busy_i` held high for 100 cycles after each start: exactly two start pulses, `tx_data_o`=0x55 then 0xAA, the second only after busy falls.
- With the RX FIFO full, a pop and a push in the same cycle: no overrun, count stays 16, and the new byte is last out.
- Store 3 bytes, then assert `rst` for one cycle before the second start: no further `tx_start_o`, and the status reads 0x1.

Source files
------------

// File: rtl/gemips_uart_pkg.sv
// Shared constants and types for the GeMIPS buffered serial port.
package gemips_uart_pkg;

    localparam logic [31:0] SERIAL_DATA_ADDR = 32'hBFD003F8;
    localparam logic [31:0] SERIAL_STAT_ADDR = 32'hBFD003FC;

    localparam int STAT_TX_RDY   = 0;
    localparam int STAT_RX_AVAIL = 1;
    localparam int STAT_OVERRUN  = 2;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        HOLD
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view; a pop frees space for a
// same-cycle push, and a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic             full,
    output logic             empty,
    output logic [W-1:0]     head,
    output logic [PTR_W:0]   count
);

    logic [W-1:0]     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_reg[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/uart_mmio_buffer.sv
// Memory-mapped serial port: RX/TX FIFOs between CPU loads/stores and the
// async receiver/transmitter pair, with a sticky receive-overrun flag.
module uart_mmio_buffer
    import gemips_uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_i,
    input  logic        reg_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [7:0]  wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rx_ready_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_clear_o,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o
);

    logic data_load, stat_load, data_store;
    assign data_load  = sel_i & re_i & ~reg_i;
    assign stat_load  = sel_i & re_i &  reg_i;
    assign data_store = sel_i & we_i & ~reg_i;

    logic           rx_take, rx_pop, rx_full, rx_empty, rx_overflow;
    logic [7:0]     rx_head;
    logic [PTR_W:0] rx_count_unused;
    logic           rx_clear_reg, overrun_reg;

    // The receiver keeps its flag up until the clear pulse lands, so the
    // cycle carrying the pulse must not capture the same byte again.
    assign rx_take     = rx_ready_i & ~rx_clear_reg;
    assign rx_pop      = data_load & ~rx_empty;
    assign rx_overflow = rx_take & rx_full & ~rx_pop;
    assign rx_clear_o  = rx_clear_reg;

    sync_fifo #(.DEPTH(DEPTH), .W(8), .PTR_W(PTR_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_take),
        .pop   (rx_pop),
        .din   (rx_data_i),
        .full  (rx_full),
        .empty (rx_empty),
        .head  (rx_head),
        .count (rx_count_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_clear_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            rx_clear_reg <= rx_take;
            overrun_reg  <= (overrun_reg & ~stat_load) | rx_overflow;
        end
    end

    logic           tx_pop, tx_full, tx_empty;
    logic [7:0]     tx_head;
    logic [PTR_W:0] tx_count_unused;
    logic [7:0]     tx_data_reg;
    tx_state_t      state_reg, state_next;

    sync_fifo #(.DEPTH(DEPTH), .W(8), .PTR_W(PTR_W)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_store),
        .pop   (tx_pop),
        .din   (wdata_i),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (tx_head),
        .count (tx_count_unused)
    );

    logic [2:0] status_bits;
    always_comb begin
        status_bits                = '0;
        status_bits[STAT_TX_RDY]   = ~tx_full;
        status_bits[STAT_RX_AVAIL] = ~rx_empty;
        status_bits[STAT_OVERRUN]  = overrun_reg;
    end

    always_comb begin
        rdata_o = '0;
        if (data_load && !rx_empty)
            rdata_o = {24'h0, rx_head};
        else if (stat_load)
            rdata_o = {29'h0, status_bits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            tx_data_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (tx_pop)
                tx_data_reg <= tx_head;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!tx_empty && !tx_busy_i) state_next = LAUNCH;
            LAUNCH:  state_next = HOLD;
            // Transmitter raises busy a cycle after start; skip that gap.
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_pop     = 1'b0;
        tx_start_o = 1'b0;
        case (state_reg)
            IDLE:    tx_pop = ~tx_empty & ~tx_busy_i;
            LAUNCH:  tx_start_o = 1'b1;
            default: ;
        endcase
    end

    assign tx_data_o = tx_data_reg;

endmodule

// File: tb/tb_uart_mmio_buffer.sv
// Self-checking bench: directed table, corner sequences, and randomized traffic
// compared every cycle against a queue-based model of the serial port.
module tb_uart_mmio_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_i, reg_i, we_i, re_i;
    logic [7:0]  wdata_i;
    logic [31:0] rdata_o;
    logic        rx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_clear_o;
    logic        tx_busy_i;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;

    always #10 clk = ~clk;

    uart_mmio_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_i      (sel_i),
        .reg_i      (reg_i),
        .we_i       (we_i),
        .re_i       (re_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .rx_ready_i (rx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_clear_o (rx_clear_o),
        .tx_busy_i  (tx_busy_i),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: byte queues plus a launch-spacing counter.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_ovr, m_clr, m_start, m_valid;
    logic [7:0] m_txd;
    int         m_k;

    logic [31:0] obs_rdata;
    bit          obs_clr, obs_start;
    logic [7:0]  start_log[$];
    int          start_cyc[$];

    typedef struct {
        bit          sel, rsel, we, re;
        logic [7:0]  wdata;
        bit          rdy;
        logic [7:0]  rxd;
        logic [31:0] exp_rdata;
        bit          exp_clr;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        logic [31:0] er;
        bit dl, sl, ds, take, launch;
        @(negedge clk);
        obs_rdata = rdata_o;
        obs_clr   = rx_clear_o;
        obs_start = tx_start_o;
        dl = sel_i && re_i && !reg_i;
        sl = sel_i && re_i && reg_i;
        ds = sel_i && we_i && !reg_i;
        if (m_valid) begin
            er = 32'h0;
            if (dl && rxq.size() != 0)
                er = {24'h0, rxq[0]};
            else if (sl)
                er = {29'h0, m_ovr, (rxq.size() != 0), (txq.size() < DEPTH)};
            check("rdata", rdata_o, er);
            check("rx_clear", {31'h0, rx_clear_o}, {31'h0, m_clr});
            check("tx_start", {31'h0, tx_start_o}, {31'h0, m_start});
            check("tx_data", {24'h0, tx_data_o}, {24'h0, m_txd});
        end
        if (tx_start_o) begin
            start_log.push_back(tx_data_o);
            start_cyc.push_back(cyc);
            $display("tx start: byte %h at cycle %0d", tx_data_o, cyc);
        end
        if (rst) begin
            rxq.delete();
            txq.delete();
            m_ovr = 0; m_clr = 0; m_start = 0; m_txd = 8'h00; m_k = 3; m_valid = 1;
        end else if (m_valid) begin
            take   = rx_ready_i && !m_clr;
            launch = (m_k >= 3) && (txq.size() != 0) && !tx_busy_i;
            if (sl) m_ovr = 0;
            if (dl && rxq.size() != 0) void'(rxq.pop_front());
            if (take) begin
                if (rxq.size() < DEPTH) rxq.push_back(rx_data_i);
                else m_ovr = 1;
            end
            m_clr = take;
            if (launch) begin
                m_txd = txq.pop_front();
                m_k = 1;
            end else if (m_k < 3) begin
                m_k++;
            end
            m_start = launch;
            if (ds && txq.size() < DEPTH) txq.push_back(wdata_i);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        sel_i = 0; reg_i = 0; we_i = 0; re_i = 0; wdata_i = 8'h00;
        rx_ready_i = 0; rx_data_i = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
        start_log.delete();
        start_cyc.delete();
    endtask

    task automatic inject(input logic [7:0] b);
        rx_ready_i = 1; rx_data_i = b;
        cycle();
        rx_ready_i = 0;
        cycle();
    endtask

    task automatic load(input bit r, output logic [31:0] v);
        sel_i = 1; re_i = 1; reg_i = r;
        cycle();
        v = obs_rdata;
        sel_i = 0; re_i = 0; reg_i = 0;
    endtask

    task automatic store(input logic [7:0] b);
        sel_i = 1; we_i = 1; reg_i = 0; wdata_i = b;
        cycle();
        sel_i = 0; we_i = 0;
    endtask

    initial begin
        logic [31:0] v;
        int busy_cnt, fall;
        bit prev_busy;

        vecs[0] = '{1, 1, 0, 1, 8'h00, 0, 8'h00, 32'h1,  0};
        vecs[1] = '{1, 0, 0, 1, 8'h00, 0, 8'h00, 32'h0,  0};
        vecs[2] = '{0, 0, 0, 0, 8'h00, 1, 8'h41, 32'h0,  0};
        vecs[3] = '{0, 0, 0, 0, 8'h00, 1, 8'h41, 32'h0,  1};
        vecs[4] = '{0, 0, 0, 0, 8'h00, 1, 8'h42, 32'h0,  0};
        vecs[5] = '{1, 1, 0, 1, 8'h00, 0, 8'h00, 32'h3,  1};
        vecs[6] = '{1, 0, 0, 1, 8'h00, 0, 8'h00, 32'h41, 0};
        vecs[7] = '{1, 0, 0, 1, 8'h00, 0, 8'h00, 32'h42, 0};
        vecs[8] = '{1, 1, 0, 1, 8'h00, 0, 8'h00, 32'h1,  0};

        m_valid = 0;
        tx_busy_i = 0;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            sel_i = vecs[i].sel; reg_i = vecs[i].rsel; we_i = vecs[i].we; re_i = vecs[i].re;
            wdata_i = vecs[i].wdata; rx_ready_i = vecs[i].rdy; rx_data_i = vecs[i].rxd;
            cycle();
            $display("vector %0d: rdata %h rx_clear %0d", i, obs_rdata, obs_clr);
            check("vec_rdata", obs_rdata, vecs[i].exp_rdata);
            check("vec_rx_clear", {31'h0, obs_clr}, {31'h0, vecs[i].exp_clr});
        end
        idle_inputs();
        check("no_start_after_reset", start_log.size(), 0);

        // 17 bytes into a 16-deep FIFO: the last one overruns.
        do_reset();
        for (int i = 0; i < 17; i++) inject(8'h10 + 8'(i));
        load(1, v);
        check("overrun_status", v, 32'h7);
        for (int i = 0; i < 16; i++) begin
            load(0, v);
            check("overrun_readback", v, 32'h10 + i);
        end
        load(1, v);
        check("overrun_cleared", v, 32'h1);

        // Full FIFO with pop and push in the same cycle.
        do_reset();
        for (int i = 0; i < 16; i++) inject(8'h20 + 8'(i));
        sel_i = 1; re_i = 1; reg_i = 0; rx_ready_i = 1; rx_data_i = 8'hEE;
        cycle();
        check("full_pop_push_head", obs_rdata, 32'h20);
        idle_inputs();
        cycle();
        load(1, v);
        check("full_pop_push_status", v, 32'h3);
        for (int i = 1; i < 16; i++) begin
            load(0, v);
            check("full_pop_push_order", v, 32'h20 + i);
        end
        load(0, v);
        check("full_pop_push_last", v, 32'hEE);
        load(1, v);
        check("full_pop_push_empty", v, 32'h1);

        // Two stores against a transmitter that stays busy 100 cycles.
        do_reset();
        store(8'h55);
        store(8'hAA);
        busy_cnt = 0; fall = -1; prev_busy = 0;
        for (int i = 0; i < 320; i++) begin
            tx_busy_i = (busy_cnt > 0);
            if (prev_busy && !tx_busy_i && fall < 0) fall = cyc;
            prev_busy = tx_busy_i;
            cycle();
            if (busy_cnt > 0) busy_cnt--;
            if (obs_start) busy_cnt = 100;
        end
        tx_busy_i = 0;
        check("tx_pulse_count", start_log.size(), 2);
        if (start_log.size() >= 2) begin
            check("tx_first_byte", {24'h0, start_log[0]}, 32'h55);
            check("tx_second_byte", {24'h0, start_log[1]}, 32'hAA);
            check("tx_second_after_busy", {31'h0, (fall >= 0) && (start_cyc[1] >= fall)}, 32'h1);
        end

        // Reset between the first and second start cancels the queue.
        do_reset();
        tx_busy_i = 1;
        store(8'h61); store(8'h62); store(8'h63);
        tx_busy_i = 0;
        cycle();
        tx_busy_i = 1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1;
        cycle();
        rst = 0;
        tx_busy_i = 0;
        for (int i = 0; i < 50; i++) cycle();
        check("reset_cancel_pulses", start_log.size(), 1);
        if (start_log.size() >= 1) check("reset_first_byte", {24'h0, start_log[0]}, 32'h61);
        load(1, v);
        check("reset_cancel_status", v, 32'h1);

        // Randomized traffic; second half keeps the transmitter mostly busy.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sel_i      = ($urandom % 4) != 0;
            reg_i      = $urandom % 2;
            re_i       = ($urandom % 3) == 0;
            we_i       = ($urandom % 3) == 0;
            wdata_i    = 8'($urandom);
            rx_ready_i = ($urandom % 3) == 0;
            rx_data_i  = 8'($urandom);
            tx_busy_i  = (i < 1500) ? (($urandom % 4) == 0) : (($urandom % 8) != 0);
            rst        = ($urandom % 700) == 0;
            cycle();
        end
        idle_inputs();
        rst = 0;
        tx_busy_i = 0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
